// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: packs symbolic MIPS instruction requests into 32-bit
// words, queues them in a small FIFO and streams them into instruction
// memory at sequential word addresses.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on internal state (never on in_valid), so the sender
// may hold its request until it sees the transfer. A transfer in a clear cycle
// still counts as accepted by the sender, but its word is dropped.
module inst_encoder_loader #(
   parameter int DEPTH     = 8,
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              im_stall,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic [15:0]       wr_count,
   output logic              err_illegal,
   output logic              done
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   // Instruction kinds as presented on in_kind
   localparam logic [3:0] K_ADD   = 4'd0;
   localparam logic [3:0] K_SUB   = 4'd1;
   localparam logic [3:0] K_OR    = 4'd2;
   localparam logic [3:0] K_ADDIU = 4'd3;
   localparam logic [3:0] K_LW    = 4'd4;
   localparam logic [3:0] K_SW    = 4'd5;
   localparam logic [3:0] K_BEQ   = 4'd6;
   localparam logic [3:0] K_LUI   = 4'd7;
   localparam logic [3:0] K_J     = 4'd8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      FLUSHING = 2'd2
   } state_t;

   state_t            state;
   logic [31:0]       mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [PW:0]       count;
   logic [ADDR_W-1:0] wr_addr;     // address the next write will use
   logic [31:0]       enc_word;
   logic              legal;
   logic              full;
   logic              empty;
   logic              accept;
   logic              push;
   logic              pop;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign in_ready = !full && (state != FLUSHING);
   assign legal    = (in_kind <= K_J);
   assign accept   = in_valid && in_ready;
   // clear wins over both FIFO operations in the same cycle
   assign push     = accept && legal && !clear;
   assign pop      = !empty && !im_stall && !clear;

   // Combinational encoder: request fields to a 32-bit MIPS word (shamt = 0)
   always_comb begin
      enc_word = 32'd0;
      case (in_kind)
         K_ADD:   enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
         K_SUB:   enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
         K_OR:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100101};
         K_ADDIU: enc_word = {6'b001001, in_rs, in_rt, in_imm};
         K_LW:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
         K_SW:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
         K_BEQ:   enc_word = {6'b000100, in_rs, in_rt, in_imm};
         K_LUI:   enc_word = {6'b001111, 5'd0, in_rt, in_imm};
         K_J:     enc_word = {6'b000010, in_target};
         default: enc_word = 32'd0;
      endcase
   end

   // FIFO storage; contents need no reset because occupancy is tracked separately
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= enc_word;
      end
   end

   // FIFO pointers/occupancy, write port, counters, error flag and state machine
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         wr_addr     <= BASE;
         im_we       <= 1'b0;
         im_addr     <= BASE;
         im_wdata    <= 32'd0;
         wr_count    <= 16'd0;
         err_illegal <= 1'b0;
         done        <= 1'b0;
         state       <= IDLE;
      end else if (clear) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         wr_addr     <= BASE;
         im_we       <= 1'b0;
         im_addr     <= BASE;
         wr_count    <= 16'd0;
         err_illegal <= 1'b0;
         done        <= 1'b0;
         state       <= IDLE;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // im_addr shows the address being written while im_we is high and
         // the next address to be written otherwise
         im_we   <= pop;
         im_addr <= wr_addr;
         if (pop) begin
            im_wdata <= mem[rd_ptr];
            wr_addr  <= wr_addr + 1'b1;
            if (wr_count != 16'hFFFF) begin
               wr_count <= wr_count + 16'd1;
            end
         end

         if (accept && !legal) begin
            err_illegal <= 1'b1;
         end

         // A flush that finds the FIFO empty completes immediately; otherwise
         // done fires on the edge after the last pop, i.e. after the last write
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (flush) begin
                  if (empty) done <= 1'b1;
                  else       state <= FLUSHING;
               end else if (!empty) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (flush) begin
                  if (empty) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     state <= FLUSHING;
                  end
               end else if (empty && !im_we) begin
                  state <= IDLE;
               end
            end
            FLUSHING: begin
               if (empty) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: a queue-based reference model of the loader
// is stepped every clock and compared with the DUT on every falling edge,
// plus directed checks of known instruction words and boundary cases.
module tb_inst_encoder_loader;

   localparam int DEPTH = 8;
   localparam int AW    = 10;

   logic          clk;
   logic          rst;
   logic          clear;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_kind;
   logic [4:0]    in_rs;
   logic [4:0]    in_rt;
   logic [4:0]    in_rd;
   logic [15:0]   in_imm;
   logic [25:0]   in_target;
   logic          im_stall;
   logic          im_we;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_wdata;
   logic [15:0]   wr_count;
   logic          err_illegal;
   logic          done;

   // second instance with a tiny wrapping address space
   logic          s_valid;
   logic          s_ready;
   logic [3:0]    s_kind;
   logic          s_we;
   logic [1:0]    s_addr;
   logic [31:0]   s_wdata;
   logic [15:0]   s_count;
   logic          s_err;
   logic          s_done;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;

   logic [31:0] wlog_d[$];
   logic [31:0] wlog_a[$];
   logic [31:0] s_log[$];

   // reference model state
   logic [31:0] m_fifo[$];
   int          m_addr;
   int          m_cnt;
   bit          m_err;
   bit          m_flushing;
   bit          m_we;
   logic [31:0] m_wdata;
   int          m_waddr;
   bit          m_done;
   bit          m_acc;
   int          m_sz;
   bit          m_rdy;
   bit          rnd_stall;

   inst_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(0)) u_dut (
      .clk(clk), .rst(rst), .clear(clear), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_target(in_target), .im_stall(im_stall), .im_we(im_we),
      .im_addr(im_addr), .im_wdata(im_wdata), .wr_count(wr_count),
      .err_illegal(err_illegal), .done(done)
   );

   inst_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(2), .BASE_ADDR(3)) u_small (
      .clk(clk), .rst(rst), .clear(1'b0), .flush(1'b0),
      .in_valid(s_valid), .in_ready(s_ready), .in_kind(s_kind),
      .in_rs(5'd1), .in_rt(5'd2), .in_rd(5'd3), .in_imm(16'd0),
      .in_target(26'd0), .im_stall(1'b0), .im_we(s_we),
      .im_addr(s_addr), .im_wdata(s_wdata), .wr_count(s_count),
      .err_illegal(s_err), .done(s_done)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Instruction word from the MIPS field layout, built arithmetically
   function automatic logic [31:0] ref_word(input int k, input int rs, input int rt,
                                            input int rd, input int imm, input int tgt);
      int op;
      int funct;
      int w;
      w = 0;
      if (k <= 2) begin
         funct = (k == 0) ? 32 : (k == 1) ? 34 : 37;
         w = rs * (2 ** 21) + rt * (2 ** 16) + rd * (2 ** 11) + funct;
      end else if (k <= 6) begin
         op = (k == 3) ? 9 : (k == 4) ? 35 : (k == 5) ? 43 : 4;
         w = op * (2 ** 26) + rs * (2 ** 21) + rt * (2 ** 16) + imm;
      end else if (k == 7) begin
         w = 15 * (2 ** 26) + rt * (2 ** 16) + imm;
      end else if (k == 8) begin
         w = 2 * (2 ** 26) + tgt;
      end
      return 32'(w);
   endfunction

   // reference model: one step per clock edge, from the inputs only
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_fifo.delete();
         m_addr = 0; m_cnt = 0; m_err = 0; m_flushing = 0;
         m_we = 0; m_done = 0; m_acc = 0; m_waddr = 0; m_wdata = 0;
      end else begin
         m_sz  = m_fifo.size();
         m_rdy = (m_sz < DEPTH) && !m_flushing;
         m_acc = in_valid && m_rdy;
         if (clear) begin
            m_fifo.delete();
            m_addr = 0; m_cnt = 0; m_err = 0; m_flushing = 0;
            m_we = 0; m_done = 0;
         end else begin
            m_done = 0;
            if (m_flushing) begin
               if (m_sz == 0) begin
                  m_done = 1; m_flushing = 0;
               end
            end else if (flush) begin
               if (m_sz == 0) m_done = 1;
               else m_flushing = 1;
            end
            m_we = (m_sz > 0) && !im_stall;
            if (m_we) begin
               m_wdata = m_fifo.pop_front();
               m_waddr = m_addr;
               m_addr  = (m_addr + 1) % (2 ** AW);
               if (m_cnt < 65535) m_cnt++;
            end
            if (m_acc) begin
               if (in_kind <= 4'd8)
                  m_fifo.push_back(ref_word(int'(in_kind), int'(in_rs), int'(in_rt),
                                            int'(in_rd), int'(in_imm), int'(in_target)));
               else
                  m_err = 1;
            end
         end
      end
   end

   // scoreboard compare on the falling edge, plus write/done logging
   always @(negedge clk) begin
      check("im_we", 32'(im_we), 32'(m_we));
      if (im_we && m_we) begin
         check("im_wdata", im_wdata, m_wdata);
         check("im_addr", 32'(im_addr), 32'(m_waddr));
      end
      check("wr_count", 32'(wr_count), 32'(m_cnt));
      check("err_illegal", 32'(err_illegal), 32'(m_err));
      check("done", 32'(done), 32'(m_done));
      check("in_ready", 32'(in_ready), 32'((m_fifo.size() < DEPTH) && !m_flushing));
      if (im_we) begin
         wlog_d.push_back(im_wdata);
         wlog_a.push_back(32'(im_addr));
      end
      if (done) n_done++;
      if (s_we) s_log.push_back(32'(s_addr));
   end

   // driver tasks (called aligned to a falling edge)
   task automatic send(input int k, input int rs, input int rt, input int rd,
                       input int imm, input int tgt);
      in_valid  = 1'b1;
      in_kind   = 4'(k);
      in_rs     = 5'(rs);
      in_rt     = 5'(rt);
      in_rd     = 5'(rd);
      in_imm    = 16'(imm);
      in_target = 26'(tgt);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (m_acc) begin
            in_valid = 1'b0;
            return;
         end
         if (rnd_stall) im_stall = ($urandom_range(0, 3) == 0);
      end
      in_valid = 1'b0;
      check("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic send_rand_legal();
      send($urandom_range(0, 8), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 67108863));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   logic [31:0] exp_words [5];

   initial begin
      rst = 1'b1; clear = 1'b0; flush = 1'b0; in_valid = 1'b0; in_kind = '0;
      in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
      im_stall = 1'b0; rnd_stall = 1'b0; s_valid = 1'b0; s_kind = '0;
      exp_words[0] = 32'h8FA80004; exp_words[1] = 32'h3C011001;
      exp_words[2] = 32'h08100000; exp_words[3] = 32'h1022FFFF;
      exp_words[4] = 32'h00A62025;

      // reset values
      idle(3);
      check("rst_im_we", 32'(im_we), 32'd0);
      check("rst_im_addr", 32'(im_addr), 32'd0);
      check("rst_im_wdata", im_wdata, 32'd0);
      check("rst_wr_count", 32'(wr_count), 32'd0);
      check("rst_err", 32'(err_illegal), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_small_addr", 32'(s_addr), 32'd3);
      rst = 1'b0;
      idle(2);

      // first ADD: written the cycle after acceptance
      send(0, 1, 2, 3, $urandom_range(0, 65535), $urandom_range(0, 1000));
      check("add_no_bypass", 32'(im_we), 32'd0);
      @(negedge clk);
      check("add_we", 32'(im_we), 32'd1);
      check("add_addr", 32'(im_addr), 32'd0);
      check("add_word", im_wdata, 32'h00221820);
      check("add_count", 32'(wr_count), 32'd1);
      idle(2);

      // back-to-back known words at addresses 0..4
      pulse_clear();
      check("clr_addr", 32'(im_addr), 32'd0);
      wlog_d.delete(); wlog_a.delete();
      send(4, 29, 8, 7, 4, 55);
      send(7, 9, 1, 7, 16'h1001, 77);
      send(8, 3, 4, 5, 6, 26'h0100000);
      send(6, 1, 2, 9, 16'hFFFF, 12);
      send(2, 5, 6, 4, 99, 13);
      idle(4);
      check("seq_len", 32'(wlog_d.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < wlog_d.size()) begin
            check("seq_word", wlog_d[i], exp_words[i]);
            check("seq_addr", wlog_a[i], 32'(i));
         end
      end

      // stall: fill 8 entries, then a gapless drain
      im_stall = 1'b1;
      for (int i = 0; i < DEPTH; i++) send_rand_legal();
      check("full_ready", 32'(in_ready), 32'd0);
      idle(2);
      check("stall_no_we", 32'(im_we), 32'd0);
      wlog_d.delete(); wlog_a.delete();
      im_stall = 1'b0;
      idle(DEPTH + 3);
      check("drain_len", 32'(wlog_d.size()), 32'(DEPTH));
      if (wlog_a.size() == DEPTH)
         check("drain_contig", wlog_a[DEPTH-1] - wlog_a[0], 32'(DEPTH - 1));
      check("drain_ready", 32'(in_ready), 32'd1);

      // illegal kind is sticky until clear
      wlog_d.delete();
      send(12, 1, 2, 3, 4, 5);
      idle(3);
      check("illegal_err", 32'(err_illegal), 32'd1);
      check("illegal_nowrite", 32'(wlog_d.size()), 32'd0);
      send(0, 7, 8, 9, 0, 0);
      idle(3);
      check("illegal_sticky", 32'(err_illegal), 32'd1);
      check("illegal_then_add", 32'(wlog_d.size()), 32'd1);
      pulse_clear();
      check("clear_err", 32'(err_illegal), 32'd0);
      check("clear_addr", 32'(im_addr), 32'd0);
      check("clear_count", 32'(wr_count), 32'd0);

      // wrapping addresses on the small instance
      s_log.delete();
      s_valid = 1'b1;
      idle(3);
      s_valid = 1'b0;
      idle(5);
      check("small_len", 32'(s_log.size()), 32'd3);
      if (s_log.size() == 3) begin
         check("small_a0", s_log[0], 32'd3);
         check("small_a1", s_log[1], 32'd0);
         check("small_a2", s_log[2], 32'd1);
      end

      // flush of 3 words
      im_stall = 1'b1;
      repeat (3) send_rand_legal();
      pulse_flush();
      check("flush_ready", 32'(in_ready), 32'd0);
      n_done = 0;
      im_stall = 1'b0;
      idle(8);
      check("flush_done_once", 32'(n_done), 32'd1);
      check("flush_ready_after", 32'(in_ready), 32'd1);
      // flush with an empty FIFO
      n_done = 0;
      pulse_flush();
      idle(3);
      check("flush_empty_done", 32'(n_done), 32'd1);

      // randomized traffic
      rnd_stall = 1'b1;
      for (int i = 0; i < 200; i++) begin
         im_stall = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) == 0)
            send($urandom_range(9, 15), 1, 2, 3, 4, 5);
         else
            send_rand_legal();
         if ($urandom_range(0, 29) == 0) pulse_flush();
         if ($urandom_range(0, 49) == 0) pulse_clear();
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      rnd_stall = 1'b0;
      im_stall = 1'b0;
      idle(DEPTH + 6);

      // reset in the middle of a flush drain
      im_stall = 1'b1;
      repeat (3) send_rand_legal();
      pulse_flush();
      im_stall = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_we", 32'(im_we), 32'd0);
      check("midrst_addr", 32'(im_addr), 32'd0);
      check("midrst_count", 32'(wr_count), 32'd0);
      check("midrst_ready", 32'(in_ready), 32'd1);
      check("midrst_done", 32'(done), 32'd0);
      idle(2);
      rst = 1'b0;
      wlog_d.delete();
      idle(6);
      check("midrst_nowrite", 32'(wlog_d.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
